sr_latch_ctrl: RTL and testbench

//  Synchronous command stage that sits directly upstream of the gated SR latch and drives its En/S/R inputs.

---
 rtl/sr_latch_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: command sequencer for a gated SR latch.
// Takes set/clear requests and drives the latch through setup, an En pulse, hold and settle.
// Then reads Q/notQ back through 2-flop synchronizers and returns the observed value plus a fault flag.
module sr_latch_ctrl #(
  parameter int EN_CYCLES     = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = 3
) (
  input  logic       Clk,
  input  logic       notRst,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic       ReqSet,
  output logic       RespValid,
  input  logic       RespReady,
  output logic       RespQ,
  output logic       RespErr,
  output logic [7:0] ErrCnt,
  output logic       En,
  output logic       S,
  output logic       R,
  input  logic       Q,
  input  logic       notQ
);

  // Reject parameter sets the sequencer cannot honour.
  if (EN_CYCLES < 1) begin : gBadEn
    $error("EN_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : gBadHold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 3) begin : gBadSettle
    $error("SETTLE_CYCLES must be >= 3 to cover the synchronizer");
  end
  if ((EN_CYCLES - 1) >= (1 << CNT_W) || (HOLD_CYCLES - 1) >= (1 << CNT_W) ||
      (SETTLE_CYCLES - 1) >= (1 << CNT_W)) begin : gBadCnt
    $error("CNT_W too narrow for the phase lengths");
  end

  localparam logic [CNT_W-1:0] EN_LOAD     = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
    HOLD   = 3'd3,
    SETTLE = 3'd4,
    RESP   = 3'd5
  } stateT;

  stateT            stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic             cmdReg, cmdNext;
  logic             enReg, enNext;
  logic             sReg, sNext;
  logic             rReg, rNext;
  logic             reqReadyReg, reqReadyNext;
  logic             respValidReg, respValidNext;
  logic             respQReg, respQNext;
  logic             respErrReg, respErrNext;
  logic [7:0]       errCntReg, errCntNext;
  logic             qMeta, qSync, nqMeta, nqSync;
  logic             errNow;

  // Two-flop synchronizers for the asynchronous latch outputs.
  always_ff @(posedge Clk or negedge notRst) begin
    if (!notRst) begin
      qMeta  <= 1'b0;
      qSync  <= 1'b0;
      nqMeta <= 1'b0;
      nqSync <= 1'b0;
    end else begin
      qMeta  <= Q;
      qSync  <= qMeta;
      nqMeta <= notQ;
      nqSync <= nqMeta;
    end
  end

  // Fault verdict for the value currently seen through the synchronizers.
  assign errNow = (qSync == nqSync) | (qSync != cmdReg);

  // Next-state and next-output logic; every latch-facing output is a flop.
  always_comb begin
    stateNext     = stateReg;
    cntNext       = cntReg;
    cmdNext       = cmdReg;
    enNext        = enReg;
    sNext         = sReg;
    rNext         = rReg;
    respValidNext = respValidReg;
    respQNext     = respQReg;
    respErrNext   = respErrReg;
    errCntNext    = errCntReg;
    unique case (stateReg)
      IDLE: begin
        if (ReqValid && reqReadyReg) begin
          stateNext = SETUP;
          cmdNext   = ReqSet;
          sNext     = ReqSet;
          rNext     = ~ReqSet;
          enNext    = 1'b0;
          cntNext   = '0;
        end
      end
      SETUP: begin
        stateNext = PULSE;
        enNext    = 1'b1;
        cntNext   = EN_LOAD;
      end
      PULSE: begin
        if (cntReg == '0) begin
          stateNext = HOLD;
          enNext    = 1'b0;
          cntNext   = HOLD_LOAD;
        end else begin
          cntNext = cntReg - 1'b1;
        end
      end
      HOLD: begin
        if (cntReg == '0) begin
          stateNext = SETTLE;
          sNext     = 1'b0;
          rNext     = 1'b0;
          cntNext   = SETTLE_LOAD;
        end else begin
          cntNext = cntReg - 1'b1;
        end
      end
      SETTLE: begin
        if (cntReg == '0) begin
          stateNext     = RESP;
          respValidNext = 1'b1;
          respQNext     = qSync;
          respErrNext   = errNow;
          if (errNow && (errCntReg != 8'd255)) begin
            errCntNext = errCntReg + 8'd1;
          end
        end else begin
          cntNext = cntReg - 1'b1;
        end
      end
      RESP: begin
        if (RespReady) begin
          stateNext     = IDLE;
          respValidNext = 1'b0;
        end
      end
      default: begin
        stateNext     = IDLE;
        enNext        = 1'b0;
        sNext         = 1'b0;
        rNext         = 1'b0;
        respValidNext = 1'b0;
      end
    endcase
    reqReadyNext = (stateNext == IDLE);
  end

  // State and registered outputs; reset drops the latch drive immediately.
  always_ff @(posedge Clk or negedge notRst) begin
    if (!notRst) begin
      stateReg     <= IDLE;
      cntReg       <= '0;
      cmdReg       <= 1'b0;
      enReg        <= 1'b0;
      sReg         <= 1'b0;
      rReg         <= 1'b0;
      reqReadyReg  <= 1'b0;
      respValidReg <= 1'b0;
      respQReg     <= 1'b0;
      respErrReg   <= 1'b0;
      errCntReg    <= 8'd0;
    end else begin
      stateReg     <= stateNext;
      cntReg       <= cntNext;
      cmdReg       <= cmdNext;
      enReg        <= enNext;
      sReg         <= sNext;
      rReg         <= rNext;
      reqReadyReg  <= reqReadyNext;
      respValidReg <= respValidNext;
      respQReg     <= respQNext;
      respErrReg   <= respErrNext;
      errCntReg    <= errCntNext;
    end
  end

  assign ReqReady  = reqReadyReg;
  assign RespValid = respValidReg;
  assign RespQ     = respQReg;
  assign RespErr   = respErrReg;
  assign ErrCnt    = errCntReg;
  assign En        = enReg;
  assign S         = sReg;
  assign R         = rReg;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: behavioural gated SR latch with injectable faults,
// randomized set/clear traffic and a per-operation schedule/result model.
module tb_sr_latch_ctrl;

  localparam int EN_C   = 2;
  localparam int HOLD_C = 1;
  localparam int SET_C  = 3;
  localparam int LAT    = 1 + EN_C + HOLD_C + SET_C;

  logic       Clk = 1'b0;
  logic       notRst = 1'b0;
  logic       ReqValid = 1'b0;
  logic       ReqReady;
  logic       ReqSet = 1'b0;
  logic       RespValid;
  logic       RespReady = 1'b0;
  logic       RespQ;
  logic       RespErr;
  logic [7:0] ErrCnt;
  logic       En, S, R;
  logic       Q, notQ;

  int checkCnt = 0;
  int failCnt  = 0;
  int modelErr = 0;
  int faultMode = 0;   // 0 healthy, 1 Q=notQ=1, 2 outputs swapped
  logic latchQ = 1'b0;

  sr_latch_ctrl #(
    .EN_CYCLES(EN_C), .HOLD_CYCLES(HOLD_C), .SETTLE_CYCLES(SET_C), .CNT_W(3)
  ) dut (
    .Clk(Clk), .notRst(notRst),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqSet(ReqSet),
    .RespValid(RespValid), .RespReady(RespReady), .RespQ(RespQ), .RespErr(RespErr),
    .ErrCnt(ErrCnt), .En(En), .S(S), .R(R), .Q(Q), .notQ(notQ)
  );

  always #5 Clk = ~Clk;

  // Gated SR latch with a gate-like propagation delay.
  always @(En or S or R) begin
    #4;
    if (En) begin
      if (S && !R) latchQ = 1'b1;
      else if (R && !S) latchQ = 1'b0;
    end
  end

  assign Q    = (faultMode == 1) ? 1'b1 : ((faultMode == 2) ? ~latchQ : latchQ);
  assign notQ = (faultMode == 1) ? 1'b1 : ((faultMode == 2) ? latchQ : ~latchQ);

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // S and R must never be asserted together.
  always @(negedge Clk) begin
    if (notRst) checkVal("sr_exclusive", {31'd0, S & R}, 32'd0);
  end

  // One full operation; starts and ends at a falling clock edge.
  task automatic doOp(input logic cmd, input int respDelay, input bit holdReq);
    logic expQ, expErr;
    int waitCnt;
    case (faultMode)
      0:       begin expQ = cmd;  expErr = 1'b0; end
      1:       begin expQ = 1'b1; expErr = 1'b1; end
      default: begin expQ = ~cmd; expErr = 1'b1; end
    endcase
    if (expErr && modelErr < 255) modelErr++;
    RespReady = (respDelay == 0);
    ReqValid  = 1'b1;
    ReqSet    = cmd;
    waitCnt   = 0;
    while (!ReqReady && waitCnt < 20) begin
      @(negedge Clk);
      waitCnt++;
    end
    if (!ReqReady) begin
      checkVal("accept_timeout", 32'd0, 32'd1);
      ReqValid = 1'b0;
      return;
    end
    @(posedge Clk);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge Clk);
      if (k == 0 && !holdReq) ReqValid = 1'b0;
      checkVal("en_sched", {31'd0, En}, {31'd0, (k >= 1 && k <= EN_C)});
      checkVal("s_sched", {31'd0, S}, {31'd0, (cmd && k <= EN_C + HOLD_C)});
      checkVal("r_sched", {31'd0, R}, {31'd0, (!cmd && k <= EN_C + HOLD_C)});
      checkVal("busy_ready", {31'd0, ReqReady}, 32'd0);
      checkVal("resp_valid_sched", {31'd0, RespValid}, {31'd0, (k == LAT)});
    end
    checkVal("resp_q", {31'd0, RespQ}, {31'd0, expQ});
    checkVal("resp_err", {31'd0, RespErr}, {31'd0, expErr});
    checkVal("err_cnt", {24'd0, ErrCnt}, modelErr);
    for (int d = 0; d < respDelay; d++) begin
      @(negedge Clk);
      checkVal("bp_valid", {31'd0, RespValid}, 32'd1);
      checkVal("bp_q", {31'd0, RespQ}, {31'd0, expQ});
      checkVal("bp_ready", {31'd0, ReqReady}, 32'd0);
      checkVal("bp_en", {31'd0, En | S | R}, 32'd0);
    end
    RespReady = 1'b1;
    @(negedge Clk);
    checkVal("resp_drop", {31'd0, RespValid}, 32'd0);
    checkVal("idle_ready", {31'd0, ReqReady}, 32'd1);
    RespReady = 1'b0;
  endtask

  initial begin
    // Reset behaviour.
    repeat (3) @(negedge Clk);
    checkVal("rst_en", {31'd0, En}, 32'd0);
    checkVal("rst_sr", {30'd0, S, R}, 32'd0);
    checkVal("rst_resp_valid", {31'd0, RespValid}, 32'd0);
    checkVal("rst_err_cnt", {24'd0, ErrCnt}, 32'd0);
    notRst = 1'b1;
    @(negedge Clk);
    checkVal("rst_release_ready", {31'd0, ReqReady}, 32'd1);

    // Directed set then clear.
    doOp(1'b1, 0, 1'b0);
    doOp(1'b0, 0, 1'b0);

    // Random healthy traffic.
    for (int i = 0; i < 100; i++) begin
      doOp(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Single fault then saturation of the fault counter.
    faultMode = 1;
    doOp(1'b1, 0, 1'b0);
    checkVal("err_cnt_one", {24'd0, ErrCnt}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      faultMode = int'($urandom_range(1, 2));
      doOp(1'($urandom_range(0, 1)), 0, 1'b0);
    end
    checkVal("err_cnt_sat", {24'd0, ErrCnt}, 32'd255);
    faultMode = 0;

    // Backpressure with a request held the whole time, then it is taken.
    doOp(1'b1, 5, 1'b1);
    doOp(1'b0, 0, 1'b0);

    // Reset in the middle of the En pulse.
    ReqValid = 1'b1;
    ReqSet   = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 1'b0;
    @(posedge Clk);
    #3;
    checkVal("mid_pulse_en", {31'd0, En}, 32'd1);
    notRst = 1'b0;
    #1;
    checkVal("async_rst_en", {31'd0, En}, 32'd0);
    checkVal("async_rst_sr", {30'd0, S, R}, 32'd0);
    checkVal("async_rst_errcnt", {24'd0, ErrCnt}, 32'd0);
    modelErr = 0;
    repeat (2) @(negedge Clk);
    notRst = 1'b1;
    @(negedge Clk);
    checkVal("post_rst_ready", {31'd0, ReqReady}, 32'd1);
    checkVal("post_rst_valid", {31'd0, RespValid}, 32'd0);
    doOp(1'b0, 1, 1'b0);
    doOp(1'b1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
    $finish;
  end

  // Hard stop if the run never completes.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
